uart_debug_cmd_parser: RTL and testbench
========================================

// Module: uart_debug_cmd_parser
// PURPOSE
//  Upstream feeder of the UART debug AXI master. Consumes bytes from the UART RX core, parses debug
//  command frames (word write, byte write, read probe, block download) and issues one-word
//  uart_debug_req transactions, waiting for store_finish/load_finish before the next. Returns a
//  one-byte ACK/NAK per command on the UART TX byte interface.
// PARAMETERS
//  TIMEOUT_CYCLES  1_000_000  max idle cycles between bytes inside a frame before abort
//  TO_W            20         width of inter-byte timeout counter
//  ACK_BYTE        8'h06      response for a completed command
//  NAK_BYTE        8'h15      response for unknown cmd / timeout / overflow
// PORTS
//  clk               in   1   single clock
//  rst               in   1   synchronous, active-high reset
//  rx_data           in   8   received byte, valid with rx_valid
//  rx_valid          in   1   one-cycle strobe per received byte (no backpressure possible)
//  tx_data           out  8   response byte
//  tx_valid          out  1   response pending; held until tx_ready
//  tx_ready          in   1   TX core accepts tx_data when tx_valid & tx_ready
//  uart_debug_req    out  1   one-cycle request pulse to AXI master
//  uart_debug_we     out  1   1=store, 0=load; stable from req until finish
//  uart_debug_addr   out  32  byte address; stable from req until finish
//  uart_debug_wdata  out  32  store data (byte store: data in [7:0])
//  uart_debug_stb    out  1   1=byte store, 0=word store
//  store_finish      in   1   one-cycle completion of a store
//  load_finish       in   1   one-cycle completion of a load
//  busy              out  1   frame in progress or AXI transaction outstanding
//  err_overflow      out  1   sticky: word/response overrun; cleared only by rst
//  err_timeout       out  1   sticky: inter-byte timeout; cleared only by rst
// BEHAVIOUR
//  - Reset: all outputs 0, state S_CMD, counters 0, pending/outstanding flags 0.
//  - Frame (multi-byte fields little-endian): cmd, addr[4], then per cmd:
//    'W'(8'h57) data[4]; 'B'(8'h42) data[1]; 'R'(8'h52) none; 'L'(8'h4C) len[2] (words) + len*data[4].
//  - States: S_CMD -> S_ADDR (4 bytes) -> {S_DATA | S_LEN} -> S_ISSUE -> S_WAIT -> S_CMD.
//    Unknown cmd byte: stay S_CMD, queue NAK_BYTE.
//  - Byte counter 2 bits, wraps 3->0 on word completion. Address assembled in addr shift reg.
//  - Issue: req high exactly one cycle the cycle after last byte of a word lands; we/addr/wdata/stb
//    driven from issue registers, unchanged until matching finish. No req while one outstanding.
//  - Wait: store_finish (we=1) or load_finish (we=0) ends transaction; finish while nothing outstanding
//    is ignored. 'W','B','R': ACK queued on finish. 'L': on each finish addr+=4 (32-bit wrap,
//    no carry flag), remaining len-=1; ACK after last finish. len=0: ACK right after len bytes.
//  - 'L' buffering: RX keeps assembling next word during S_WAIT into one-deep pending reg; pending is
//    issued the cycle after finish. Word completing while pending already full -> err_overflow=1,
//    frame aborted after outstanding finish, NAK queued.
//  - Timeout: counter clears on every rx_valid, counts in S_ADDR/S_LEN/S_DATA only when no AXI
//    outstanding; reaching TIMEOUT_CYCLES -> err_timeout=1, NAK queued, S_CMD.
//  - TX: one-entry register. Parser never stalls on TX; response generated while tx_valid=1 is
//    dropped and sets err_overflow. rx_valid in same cycle as a finish is captured normally.
//  - rst mid-frame or mid-transaction: immediate return to reset state; in-flight AXI completion
//    after reset is ignored (downstream is reset by the same system reset).
// STRUCTURE
//  - Shared package uart_debug_pkg: command byte codes, ACK/NAK values, state encoding localparams.
//  - One natural sub-module: uart_debug_word_asm (byte-counter + 32-bit little-endian shift register,
//    used for both addr and data assembly). Timeout counter and TX register inline.
// TESTING
//  - 'W' 00 10 00 1C 78 56 34 12 -> req once, we=1, addr=1C001000, wdata=12345678, stb=0; store_finish
//    after 5 cycles -> tx_data=06.
//  - 'B' 03 10 00 1C AB -> addr=1C001003, wdata[7:0]=AB, stb=1; store_finish -> ACK.
//  - 'L' addr 1C000000 len 03 00 + 3 words, finish delayed 20 cycles each -> 3 reqs at
//    1C000000/04/08, never two outstanding, single ACK after third finish.
//  - 'L' with finish withheld while 2 further words arrive -> err_overflow=1, NAK, back to S_CMD.
//  - 'W' with 3 addr bytes then silence TIMEOUT_CYCLES -> err_timeout=1, NAK, no req; next valid frame works.
//  - Byte 8'h00 as cmd -> NAK, no req; rst asserted between req and finish -> outputs 0, S_CMD.

Source files
------------

// File: rtl/uart_debug_pkg.sv
// Shared constants for the UART debug command parser.
// Holds command codes, response bytes and the parser FSM encoding.
package uart_debug_pkg;
   localparam logic [7:0] CMD_WORD  = 8'h57;
   localparam logic [7:0] CMD_BYTE  = 8'h42;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] CMD_BLOCK = 8'h4C;

   localparam logic [7:0] RSP_ACK = 8'h06;
   localparam logic [7:0] RSP_NAK = 8'h15;

   localparam logic [2:0] S_CMD   = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_LEN   = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_ISSUE = 3'd4;
   localparam logic [2:0] S_WAIT  = 3'd5;

   function automatic logic cmd_known(input logic [7:0] c);
      return (c == CMD_WORD) || (c == CMD_BYTE) || (c == CMD_READ) || (c == CMD_BLOCK);
   endfunction
endpackage

// File: rtl/uart_debug_word_asm.sv
// Little-endian byte-to-word assembler; word_dat is the completed value, right-aligned,
// valid combinationally in the cycle word_done is high (the last byte's strobe).
module uart_debug_word_asm (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        byte_vld,
   input  logic [7:0]  byte_dat,
   input  logic [1:0]  last_idx,
   output logic        word_done,
   output logic [31:0] word_dat
);
   logic [1:0]  cnt;
   logic [31:0] sh;
   logic [31:0] sh_nxt;

   assign sh_nxt    = {byte_dat, sh[31:8]};
   assign word_done = byte_vld && (cnt == last_idx);
   // Short fields (1 or 2 bytes) sit at the top of the shift register; realign to bit 0.
   assign word_dat  = sh_nxt >> {(2'd3 - last_idx), 3'b000};

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= 2'd0;
         sh  <= 32'h0;
      end else if (byte_vld) begin
         sh  <= sh_nxt;
         cnt <= word_done ? 2'd0 : cnt + 2'd1;
      end
   end
endmodule

// File: rtl/uart_debug_cmd_parser.sv
// Parses UART debug frames into one-word debug-bus transactions, one outstanding at a time.
// Requests issue the cycle after a word's last byte; ACK/NAK reaches TX one cycle after the event.
module uart_debug_cmd_parser
   import uart_debug_pkg::*;
#(
   parameter int         TIMEOUT_CYCLES = 1_000_000,
   parameter int         TO_W           = 20,
   parameter logic [7:0] ACK_BYTE       = RSP_ACK,
   parameter logic [7:0] NAK_BYTE       = RSP_NAK
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        uart_debug_req,
   output logic        uart_debug_we,
   output logic [31:0] uart_debug_addr,
   output logic [31:0] uart_debug_wdata,
   output logic        uart_debug_stb,
   input  logic        store_finish,
   input  logic        load_finish,
   output logic        busy,
   output logic        err_overflow,
   output logic        err_timeout
);
   logic [2:0]      state;
   logic [7:0]      cmd;
   logic [31:0]     frame_addr;
   logic [15:0]     len_rx;
   logic [15:0]     len_rem;
   logic            pend_vld;
   logic [31:0]     pend_dat;
   logic            abort;
   logic [TO_W-1:0] to_cnt;
   logic            rsp_vld;
   logic [7:0]      rsp_dat;

   logic        is_blk, axi_busy, fin_hit, to_run, to_hit;
   logic        asm_vld, asm_clr, asm_done;
   logic [1:0]  asm_last;
   logic [31:0] asm_word;

   assign is_blk   = (cmd == CMD_BLOCK);
   assign axi_busy = (state == S_ISSUE) || (state == S_WAIT);
   assign fin_hit  = axi_busy && (uart_debug_we ? store_finish : load_finish);
   assign to_run   = (state == S_ADDR) || (state == S_LEN) || (state == S_DATA);
   assign to_hit   = to_run && !rx_valid && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign asm_clr  = (state == S_CMD);
   // Block downloads keep assembling the next word while a transaction is in flight.
   assign asm_vld  = rx_valid && (to_run || (axi_busy && is_blk && !abort && (len_rx != 16'd0)));
   assign asm_last = (state == S_LEN) ? 2'd1 :
                     ((state != S_ADDR) && (cmd == CMD_BYTE)) ? 2'd0 : 2'd3;

   assign uart_debug_req = (state == S_ISSUE);
   assign busy           = (state != S_CMD);

   uart_debug_word_asm u_asm (
      .clk       (clk),
      .rst       (rst),
      .clr       (asm_clr),
      .byte_vld  (asm_vld),
      .byte_dat  (rx_data),
      .last_idx  (asm_last),
      .word_done (asm_done),
      .word_dat  (asm_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_CMD;
         cmd              <= 8'h0;
         frame_addr       <= 32'h0;
         len_rx           <= 16'h0;
         len_rem          <= 16'h0;
         pend_vld         <= 1'b0;
         pend_dat         <= 32'h0;
         abort            <= 1'b0;
         to_cnt           <= '0;
         rsp_vld          <= 1'b0;
         rsp_dat          <= 8'h0;
         tx_valid         <= 1'b0;
         tx_data          <= 8'h0;
         uart_debug_we    <= 1'b0;
         uart_debug_addr  <= 32'h0;
         uart_debug_wdata <= 32'h0;
         uart_debug_stb   <= 1'b0;
         err_overflow     <= 1'b0;
         err_timeout      <= 1'b0;
      end else begin
         rsp_vld <= 1'b0;
         to_cnt  <= (rx_valid || !to_run) ? '0 : to_cnt + TO_W'(1);

         if (tx_valid && tx_ready)
            tx_valid <= 1'b0;
         if (rsp_vld) begin
            if (tx_valid && !tx_ready)
               err_overflow <= 1'b1;
            else begin
               tx_valid <= 1'b1;
               tx_data  <= rsp_dat;
            end
         end

         if (to_hit) begin
            err_timeout <= 1'b1;
            rsp_vld     <= 1'b1;
            rsp_dat     <= NAK_BYTE;
            state       <= S_CMD;
         end else begin
            case (state)
               S_CMD: begin
                  pend_vld <= 1'b0;
                  abort    <= 1'b0;
                  if (rx_valid) begin
                     cmd <= rx_data;
                     if (cmd_known(rx_data))
                        state <= S_ADDR;
                     else begin
                        rsp_vld <= 1'b1;
                        rsp_dat <= NAK_BYTE;
                     end
                  end
               end
               S_ADDR: if (asm_done) begin
                  frame_addr <= asm_word;
                  if (cmd == CMD_READ) begin
                     uart_debug_we    <= 1'b0;
                     uart_debug_addr  <= asm_word;
                     uart_debug_wdata <= 32'h0;
                     uart_debug_stb   <= 1'b0;
                     state            <= S_ISSUE;
                  end else
                     state <= is_blk ? S_LEN : S_DATA;
               end
               S_LEN: if (asm_done) begin
                  len_rx  <= asm_word[15:0];
                  len_rem <= asm_word[15:0];
                  if (asm_word[15:0] == 16'd0) begin
                     rsp_vld <= 1'b1;
                     rsp_dat <= ACK_BYTE;
                     state   <= S_CMD;
                  end else
                     state <= S_DATA;
               end
               S_DATA: if (asm_done) begin
                  uart_debug_we    <= 1'b1;
                  uart_debug_addr  <= frame_addr;
                  uart_debug_wdata <= asm_word;
                  uart_debug_stb   <= (cmd == CMD_BYTE);
                  if (is_blk)
                     len_rx <= len_rx - 16'd1;
                  state <= S_ISSUE;
               end
               S_ISSUE, S_WAIT: begin
                  if (state == S_ISSUE)
                     state <= S_WAIT;
                  if (asm_done)
                     len_rx <= len_rx - 16'd1;
                  if (fin_hit) begin
                     if (!is_blk || abort || (len_rem == 16'd1)) begin
                        rsp_vld <= 1'b1;
                        rsp_dat <= abort ? NAK_BYTE : ACK_BYTE;
                        state   <= S_CMD;
                     end else begin
                        frame_addr      <= frame_addr + 32'd4;
                        uart_debug_addr <= frame_addr + 32'd4;
                        len_rem         <= len_rem - 16'd1;
                        if (pend_vld || asm_done) begin
                           uart_debug_wdata <= pend_vld ? pend_dat : asm_word;
                           pend_vld         <= pend_vld && asm_done;
                           pend_dat         <= asm_word;
                           state            <= S_ISSUE;
                        end else
                           state <= S_DATA;
                     end
                  end else if (asm_done) begin
                     if (pend_vld) begin
                        err_overflow <= 1'b1;
                        abort        <= 1'b1;
                     end else begin
                        pend_vld <= 1'b1;
                        pend_dat <= asm_word;
                     end
                  end
               end
               default: state <= S_CMD;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_debug_cmd_parser.sv
// Scoreboard bench for uart_debug_cmd_parser: frame-level reference model feeds expectation queues.
`timescale 1ns/1ps
module tb_uart_debug_cmd_parser;
   localparam int         TO_CYC = 60;
   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;
   localparam logic [7:0] CW = 8'h57, CB = 8'h42, CR = 8'h52, CL = 8'h4C;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h0;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        req, we, stb;
   logic [31:0] addr, wdata;
   logic        store_finish = 1'b0;
   logic        load_finish = 1'b0;
   logic        busy, err_overflow, err_timeout;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        stb;
   } txn_t;

   txn_t        exp_req[$];
   logic [7:0]  exp_tx[$];
   logic [31:0] dq[$];
   int          checks = 0;
   int          errors = 0;
   int          fin_delay = 0;
   bit          hold_fin = 1'b0;
   bit          mon_out = 1'b0;
   bit          rsp_we = 1'b0;
   txn_t        cur;
   int          cyc = 0;

   uart_debug_cmd_parser #(.TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk              (clk),
      .rst              (rst),
      .rx_data          (rx_data),
      .rx_valid         (rx_valid),
      .tx_data          (tx_data),
      .tx_valid         (tx_valid),
      .tx_ready         (tx_ready),
      .uart_debug_req   (req),
      .uart_debug_we    (we),
      .uart_debug_addr  (addr),
      .uart_debug_wdata (wdata),
      .uart_debug_stb   (stb),
      .store_finish     (store_finish),
      .load_finish      (load_finish),
      .busy             (busy),
      .err_overflow     (err_overflow),
      .err_timeout      (err_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign tx_ready = (cyc % 3) != 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit known(input logic [7:0] c);
      return (c == CW) || (c == CB) || (c == CR) || (c == CL);
   endfunction

   // Monitor: pops expectations whenever the DUT presents a request or a TX byte.
   initial begin : monitor
      txn_t e;
      forever begin
         @(negedge clk);
         if (rst) mon_out = 1'b0;
         else begin
            if ((store_finish || load_finish) && mon_out) begin
               check("hold_we", we, cur.we);
               check("hold_addr", addr, cur.addr);
               if (cur.we) check("hold_wdata", wdata, cur.wdata);
               mon_out = 1'b0;
            end
            if (req) begin
               check("one_outstanding", mon_out, 0);
               if (exp_req.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_req: got addr %h we %b, none expected", addr, we);
               end else begin
                  e = exp_req.pop_front();
                  check("req_we", we, e.we);
                  check("req_addr", addr, e.addr);
                  check("req_stb", stb, e.stb);
                  if (e.we) check("req_wdata", wdata, e.wdata);
               end
               cur = '{we, addr, wdata, stb};
               mon_out = 1'b1;
            end
            if (tx_valid && tx_ready) begin
               if (exp_tx.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_tx: got %h, none expected", tx_data);
               end else
                  check("tx_byte", tx_data, exp_tx.pop_front());
            end
         end
      end
   end

   // Debug-bus responder: completes each request after fin_delay cycles unless held.
   initial begin : responder
      forever begin
         @(negedge clk);
         if (req && !rst) begin
            rsp_we = we;
            while (hold_fin) @(posedge clk);
            repeat (fin_delay) @(posedge clk);
            @(posedge clk); #1;
            if (rsp_we) store_finish = 1'b1; else load_finish = 1'b1;
            @(posedge clk); #1;
            store_finish = 1'b0;
            load_finish  = 1'b0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(posedge clk); #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   task automatic send_word(input logic [31:0] w, input int nb, input int gap);
      for (int i = 0; i < nb; i++) send_byte(w[8*i +: 8], gap);
   endtask

   // Reference model: expected requests and response for one complete frame.
   task automatic expect_frame(input logic [7:0] c, input logic [31:0] a);
      if (c == CW) exp_req.push_back('{1'b1, a, dq[0], 1'b0});
      else if (c == CB) exp_req.push_back('{1'b1, a, {24'h0, dq[0][7:0]}, 1'b1});
      else if (c == CR) exp_req.push_back('{1'b0, a, 32'h0, 1'b0});
      else if (c == CL)
         for (int i = 0; i < dq.size(); i++) exp_req.push_back('{1'b1, a + 32'(4 * i), dq[i], 1'b0});
      exp_tx.push_back(known(c) ? ACK : NAK);
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [31:0] a, input int gap);
      logic [31:0] n;
      send_byte(c, gap);
      if (known(c)) begin
         send_word(a, 4, gap);
         if (c == CW) send_word(dq[0], 4, gap);
         else if (c == CB) send_word(dq[0], 1, gap);
         else if (c == CL) begin
            n = 32'(dq.size());
            send_word(n, 2, gap);
            for (int i = 0; i < dq.size(); i++) send_word(dq[i], 4, gap);
         end
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (exp_tx.size() == 0 && exp_req.size() == 0 && !busy && !tx_valid) begin
            done = 1'b1;
            break;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_idle: gave up with %0d reqs and %0d tx bytes still expected",
                  name, exp_req.size(), exp_tx.size());
         exp_req.delete();
         exp_tx.delete();
      end
   endtask

   task automatic frame(input logic [7:0] c, input logic [31:0] a, input int gap);
      expect_frame(c, a);
      send_frame(c, a, gap);
      wait_idle("frame", 3000);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   initial begin : main
      logic [7:0]  c;
      logic [31:0] a;
      int          kind;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_req", req, 0);
      check("rst_busy", busy, 0);
      check("rst_we", we, 0);
      check("rst_addr", addr, 0);
      check("rst_wdata", wdata, 0);
      check("rst_stb", stb, 0);
      check("rst_err_overflow", err_overflow, 0);
      check("rst_err_timeout", err_timeout, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      fin_delay = 5;
      dq = '{32'h1234_5678};
      frame(CW, 32'h1C00_1000, 3);
      dq = '{32'h0000_00AB};
      frame(CB, 32'h1C00_1003, 2);
      fin_delay = 20;
      dq = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
      frame(CL, 32'h1C00_0000, 2);
      dq.delete();
      frame(CL, 32'h2000_0000, 2);
      fin_delay = 0;
      dq = '{32'hA5A5_0001, 32'h5A5A_0002};
      frame(CL, 32'hFFFF_FFFC, 2);

      for (int it = 0; it < 25; it++) begin
         kind = $urandom_range(0, 4);
         fin_delay = $urandom_range(0, 8);
         a = $urandom;
         if ($urandom_range(0, 4) == 0) a = 32'hFFFF_FFF8;
         dq.delete();
         case (kind)
            0: c = CW;
            1: c = CB;
            2: c = CR;
            3: c = CL;
            default: begin
               c = 8'($urandom);
               while (known(c)) c = 8'($urandom);
            end
         endcase
         if (c == CW || c == CB) dq.push_back($urandom);
         if (c == CL) for (int j = 0; j < $urandom_range(0, 4); j++) dq.push_back($urandom);
         frame(c, a, $urandom_range(2, 5));
      end
      check("no_overflow_yet", err_overflow, 0);
      check("no_timeout_yet", err_timeout, 0);

      hold_fin  = 1'b1;
      fin_delay = 0;
      dq = '{32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003};
      exp_req.push_back('{1'b1, 32'h1C00_0100, 32'hDEAD_0001, 1'b0});
      exp_tx.push_back(NAK);
      send_frame(CL, 32'h1C00_0100, 2);
      repeat (5) @(posedge clk);
      hold_fin = 1'b0;
      wait_idle("overflow", 500);
      check("err_overflow_set", err_overflow, 1);
      check("overflow_idle", busy, 0);

      exp_tx.push_back(NAK);
      send_byte(CW, 2);
      send_word(32'h0000_1000, 3, 2);
      wait_idle("timeout", 400);
      check("err_timeout_set", err_timeout, 1);
      dq = '{32'hCAFE_F00D};
      frame(CW, 32'h1C00_2000, 2);

      dq.delete();
      frame(8'h00, 32'h0, 2);

      hold_fin = 1'b1;
      exp_req.push_back('{1'b0, 32'h1C00_3000, 32'h0, 1'b0});
      send_frame(CR, 32'h1C00_3000, 2);
      for (int i = 0; i < 50 && exp_req.size() != 0; i++) @(negedge clk);
      check("rst_test_req_seen", exp_req.size(), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_req", req, 0);
      check("midrst_busy", busy, 0);
      check("midrst_we_addr", {we, stb, addr}, 0);
      check("midrst_err_overflow", err_overflow, 0);
      check("midrst_err_timeout", err_timeout, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      hold_fin = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_tx_valid", tx_valid, 0);
      fin_delay = 2;
      dq = '{32'h0BAD_BEEF};
      frame(CW, 32'h1C00_4000, 2);

      check("left_req", exp_req.size(), 0);
      check("left_tx", exp_tx.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
